// File: rtl/whack_btn_conditioner_pkg.sv
// Shared types and helpers for the whack-a-mole button conditioner.
// The package is named whack_pkg; it holds default sizes, vector types and popcount.
package whack_pkg;

  localparam int N_BTN_DEF     = 4;
  localparam int DB_CYCLES_DEF = 4;
  localparam int POP_W         = $clog2(N_BTN_DEF + 1);

  typedef logic [N_BTN_DEF-1:0] btn_vec_t;
  typedef logic [POP_W-1:0]     pop_t;

  function automatic pop_t popcount(input btn_vec_t v);
    pop_t c;
    c = '0;
    for (int i = 0; i < N_BTN_DEF; i++) begin
      c = c + pop_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/whack_btn_debounce.sv
// One button: two-flop synchroniser, run-length debounce counter, debounced
// state and its one-cycle-delayed copy, plus the combinational press edge.
module whack_btn_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic st,
  output logic st_prev,
  output logic pe
);

  logic            meta_q, sync_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            st_q, st_d;
  logic            prev_q;

  // The counter only ever runs while sync disagrees with st, and clears on toggle.
  always_comb begin
    cnt_d = '0;
    st_d  = st_q;
    if (sync_q != st_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        st_d  = ~st_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      st_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      prev_q <= st_q;
    end
  end

  assign st      = st_q;
  assign st_prev = prev_q;
  assign pe      = st_q & ~prev_q;

endmodule

// File: rtl/whack_btn_conditioner.sv
// Debounces N_BTN raw buttons and emits one-cycle hit pulses on press edges.
// Define CHEAT_DETECT_EN to reject simultaneous presses and mashing (cheat pulse).
module whack_btn_conditioner
  import whack_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] hit,
  output logic [N_BTN-1:0] held,
  output logic             cheat
);

  logic [N_BTN-1:0] st, st_prev, pe;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      whack_btn_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
      ) u_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_raw[gi]),
        .st     (st[gi]),
        .st_prev(st_prev[gi]),
        .pe     (pe[gi])
      );
    end
  endgenerate

  logic [N_BTN-1:0] hit_q, hit_d;
  logic             cheat_q, cheat_d;

`ifdef CHEAT_DETECT_EN
  pop_t n_press;

  // A press is legitimate only when it is the sole press and nothing else was held.
  always_comb begin
    hit_d   = '0;
    cheat_d = 1'b0;
    n_press = popcount(btn_vec_t'(pe));
    if (n_press >= pop_t'(2) || (n_press == pop_t'(1) && |(st_prev & ~pe))) begin
      cheat_d = 1'b1;
    end else if (n_press == pop_t'(1)) begin
      hit_d = pe;
    end
  end
`else
  logic unused_st_prev;
  assign unused_st_prev = ^st_prev;

  always_comb begin
    hit_d   = pe;
    cheat_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q   <= '0;
      cheat_q <= 1'b0;
    end else begin
      hit_q   <= hit_d;
      cheat_q <= cheat_d;
    end
  end

  assign hit   = hit_q;
  assign cheat = cheat_q;
  assign held  = st;

endmodule

// File: tb/tb_whack_btn_conditioner.sv
// Directed bench for whack_btn_conditioner with a sample-history reference model.
// Honours CHEAT_DETECT_EN the same way the design does.
module tb_whack_btn_conditioner;

  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int MAXE = 4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] hit, held;
  logic         cheat;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  whack_btn_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .DB_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .hit    (hit),
    .held   (held),
    .cheat  (cheat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: the debounce input seen at edge x is the raw value sampled two
  // edges earlier (zero if a reset intervened); st flips once DB consecutive inputs
  // disagree with it, with no reset inside that window.
  logic [N-1:0] raw_h [0:MAXE-1];
  bit           rst_h [0:MAXE-1];
  logic [N-1:0] in_h  [0:MAXE-1];
  logic [N-1:0] m_st = '0, m_prev = '0, m_hit = '0;
  logic         m_cheat = 1'b0;
  int           e = 0;

  always @(posedge clk) begin : model
    logic [N-1:0] pe, new_st;
    int np;
    bit flip;
    if (e < MAXE) begin
      raw_h[e] = btn_raw;
      rst_h[e] = !rst_n;
      if (!rst_n) begin
        m_st = '0; m_prev = '0; m_hit = '0; m_cheat = 1'b0; in_h[e] = '0;
      end else begin
        pe = m_st & ~m_prev;
        np = $countones(pe);
`ifdef CHEAT_DETECT_EN
        if (np >= 2 || (np == 1 && (m_prev & ~pe) != '0)) begin
          m_hit = '0; m_cheat = 1'b1;
        end else begin
          m_hit = (np == 1) ? pe : '0; m_cheat = 1'b0;
        end
`else
        m_hit = pe; m_cheat = 1'b0;
`endif
        in_h[e] = (e >= 2 && !rst_h[e-1] && !rst_h[e-2]) ? raw_h[e-2] : '0;
        new_st = m_st;
        for (int b = 0; b < N; b++) begin
          flip = 1'b1;
          for (int j = 0; j < DB; j++) begin
            if (e - j < 0) flip = 1'b0;
            else if (rst_h[e-j] || in_h[e-j][b] == m_st[b]) flip = 1'b0;
          end
          if (flip) new_st[b] = ~m_st[b];
        end
        m_prev = m_st;
        m_st   = new_st;
      end
      e++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle{hit,held,cheat}", {23'd0, hit, held, cheat}, {23'd0, m_hit, m_st, m_cheat});
    end
  end

  int hits3;

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;
    step(3);
    chk_en = 1'b1;
    check("reset_outputs", {23'd0, hit, held, cheat}, 32'd0);
    rst_n = 1'b1;
    step(2);

    // 1: single press, 6-edge latency, single-cycle pulse, debounced release
    btn_raw = 4'b0001;
    step(6);
    check("t1_hit_early", {28'd0, hit}, 32'h0);
    step(1);
    check("t1_hit", {28'd0, hit}, 32'h1);
    check("t1_cheat", {31'd0, cheat}, 32'h0);
    check("t1_held", {28'd0, held}, 32'h1);
    step(1);
    check("t1_hit_one_cycle", {28'd0, hit}, 32'h0);
    btn_raw = 4'b0000;
    step(5);
    check("t1_held_before_release", {28'd0, held}, 32'h1);
    step(1);
    check("t1_held_released", {28'd0, held}, 32'h0);
    step(4);

    // 2: glitch shorter than the debounce window
    btn_raw = 4'b0010;
    step(3);
    btn_raw = 4'b0000;
    step(10);
    check("t2_held", {28'd0, held}, 32'h0);

    // 3: all four pressed together
    btn_raw = 4'b1111;
    step(7);
`ifdef CHEAT_DETECT_EN
    check("t3_hit", {28'd0, hit}, 32'h0);
    check("t3_cheat", {31'd0, cheat}, 32'h1);
`else
    check("t3_hit", {28'd0, hit}, 32'hF);
    check("t3_cheat", {31'd0, cheat}, 32'h0);
`endif
    step(1);
    check("t3_after", {27'd0, hit, cheat}, 32'h0);
    btn_raw = 4'b0000;
    step(8);

    // 4: mashing while button 2 is held, then a clean press of button 1
    btn_raw = 4'b0100;
    step(8);
    btn_raw = 4'b0110;
    step(7);
`ifdef CHEAT_DETECT_EN
    check("t4_mash_hit", {28'd0, hit}, 32'h0);
    check("t4_mash_cheat", {31'd0, cheat}, 32'h1);
`else
    check("t4_mash_hit", {28'd0, hit}, 32'h2);
    check("t4_mash_cheat", {31'd0, cheat}, 32'h0);
`endif
    step(1);
    btn_raw = 4'b0000;
    step(8);
    btn_raw = 4'b0010;
    step(7);
    check("t4_clean_hit", {28'd0, hit}, 32'h2);
    check("t4_clean_cheat", {31'd0, cheat}, 32'h0);
    step(1);
    btn_raw = 4'b0000;
    step(8);

    // 5: bounce on button 3 yields exactly one hit
    hits3 = 0;
    btn_raw = 4'b1000; step(1); if (hit == 4'b1000) hits3++;
    btn_raw = 4'b0000; step(1); if (hit == 4'b1000) hits3++;
    btn_raw = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (hit == 4'b1000) hits3++;
    end
    check("t5_single_hit", hits3, 32'd1);
    btn_raw = 4'b0000;
    step(8);

    // 6: reset mid-debounce with button 0 held through it
    btn_raw = 4'b0001;
    step(2);
    rst_n = 1'b0;
    step(2);
    check("t6_reset_outputs", {23'd0, hit, held, cheat}, 32'd0);
    rst_n = 1'b1;
    step(6);
    check("t6_hit_early", {28'd0, hit}, 32'h0);
    step(1);
    check("t6_hit", {28'd0, hit}, 32'h1);
    btn_raw = 4'b0000;
    step(8);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
